// File: rtl/lcd_mem_pkg.sv
// Shared definitions for the LCD_CTRL image memory host.
// Holds the host state encoding and the image geometry used by the
// controller, the memory host and their testbenches.
package lcd_mem_pkg;

  localparam int unsigned IMG_DEPTH  = 64;
  localparam int unsigned IMG_ADDR_W = 6;
  localparam int unsigned PIX_W      = 8;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DUMP  = 2'd2,
    FIN   = 2'd3
  } mem_state_e;

endpackage

// File: rtl/lcd_pix_array.sv
// Pixel storage array: DEPTH x DATA_W, one synchronous write port and
// one asynchronous read port, with an optional synchronous fill on reset.
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-high; fills every entry when INIT_EN
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  mem[raddr], combinational
module lcd_pix_array #(
  parameter int unsigned       DEPTH    = 64,
  parameter int unsigned       DATA_W   = 8,
  parameter bit                INIT_EN  = 1'b0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage update; the fill on reset takes priority over a pending write.
  always_ff @(posedge clk) begin
    if (INIT_EN && reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[AW'(i)] <= INIT_VAL;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lcd_img_mem_host.sv
// Memory-side responder for LCD_CTRL. Owns the source image (IROM) and the
// result image (IRAM). The host streams the image in, the controller reads
// IROM and writes IRAM, and after done the result is streamed back out.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   load_valid/load_data/load_ready     host image load stream (LOAD only)
//   IROM_rd/IROM_A/IROM_Q               controller read port, 1-cycle latency
//   IRAM_valid/IRAM_A/IRAM_D            controller write port
//   done                                controller finished
//   img_ready                           image loaded, controller may run
//   dump_valid/addr/data/last/ready     result dump stream
//   proto_err                           sticky protocol violation flag
module lcd_img_mem_host
  import lcd_mem_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IMG_ADDR_W,
  parameter int unsigned       DATA_W   = PIX_W,
  parameter logic [DATA_W-1:0] RAM_INIT = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              IROM_rd,
  input  logic [ADDR_W-1:0] IROM_A,
  output logic [DATA_W-1:0] IROM_Q,
  input  logic              IRAM_valid,
  input  logic [ADDR_W-1:0] IRAM_A,
  input  logic [DATA_W-1:0] IRAM_D,
  input  logic              done,
  output logic              img_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  input  logic              dump_ready,
  output logic              proto_err
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  mem_state_e        state, state_nxt;
  logic [ADDR_W-1:0] load_ptr;
  logic [ADDR_W-1:0] dump_ptr;
  logic [DATA_W-1:0] irom_rdata;

  logic in_load, in_serve, in_dump;
  logic load_acc, dump_acc, irom_rd_ok, iram_wr_ok, bad_access;

  assign in_load    = (state == LOAD);
  assign in_serve   = (state == SERVE);
  assign in_dump    = (state == DUMP);
  assign load_acc   = load_valid & in_load;
  assign dump_acc   = dump_ready & in_dump;
  assign irom_rd_ok = IROM_rd & in_serve;
  assign iram_wr_ok = IRAM_valid & in_serve;
  assign bad_access = ((IROM_rd | IRAM_valid) & ~in_serve) | (load_valid & ~in_load);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (load_acc && (load_ptr == LAST_ADDR)) state_nxt = SERVE;
      SERVE:   if (done) state_nxt = DUMP;
      DUMP:    if (dump_acc && (dump_ptr == LAST_ADDR)) state_nxt = FIN;
      FIN:     state_nxt = FIN;
      default: state_nxt = LOAD;
    endcase
  end

  // Stream handshake outputs decoded from the registered state.
  always_comb begin
    load_ready = 1'b0;
    img_ready  = 1'b0;
    dump_valid = 1'b0;
    dump_last  = 1'b0;
    case (state)
      LOAD:  load_ready = 1'b1;
      SERVE: img_ready  = 1'b1;
      DUMP: begin
        dump_valid = 1'b1;
        dump_last  = (dump_ptr == LAST_ADDR);
      end
      default: ;
    endcase
  end

  // Load and dump pointers; the dump pointer is rearmed while serving.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_ptr <= '0;
      dump_ptr <= '0;
    end else begin
      if (load_acc) load_ptr <= load_ptr + ADDR_W'(1);
      if (in_serve) begin
        dump_ptr <= '0;
      end else if (dump_acc) begin
        dump_ptr <= dump_ptr + ADDR_W'(1);
      end
    end
  end

  // Registered IROM read data; holds when no valid read is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      IROM_Q <= '0;
    end else if (irom_rd_ok) begin
      IROM_Q <= irom_rdata;
    end
  end

  // Sticky protocol error.
  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err <= 1'b0;
    end else if (bad_access) begin
      proto_err <= 1'b1;
    end
  end

  // Source image: written by the load stream, never cleared by reset.
  lcd_pix_array #(
    .DEPTH   (DEPTH),
    .DATA_W  (DATA_W),
    .INIT_EN (1'b0),
    .INIT_VAL('0)
  ) u_irom (
    .clk  (clk),
    .reset(reset),
    .we   (load_acc),
    .waddr(load_ptr),
    .wdata(load_data),
    .raddr(IROM_A),
    .rdata(irom_rdata)
  );

  // Result image: written by the controller, filled with RAM_INIT on reset.
  lcd_pix_array #(
    .DEPTH   (DEPTH),
    .DATA_W  (DATA_W),
    .INIT_EN (1'b1),
    .INIT_VAL(RAM_INIT)
  ) u_iram (
    .clk  (clk),
    .reset(reset),
    .we   (iram_wr_ok),
    .waddr(IRAM_A),
    .wdata(IRAM_D),
    .raddr(dump_ptr),
    .rdata(dump_data)
  );

  assign dump_addr = dump_ptr;

endmodule
